// File: rtl/tlc_pkg.sv
// tlc_pkg: shared state encoding and default sizing for the TLC LED-driver sequencer.
//   GS_BITS_DEF   - default grayscale counter width (PWM frame = 2^GS_BITS GCLK pulses)
//   SHIFT_LEN_DEF - default serial bits per driver load
//   state_t       - sequencer states: shifting, load complete, latching
package tlc_pkg;
  localparam int GS_BITS_DEF = 12;
  localparam int SHIFT_LEN_DEF = 288;
  typedef enum logic [1:0] {ST_SHIFT, ST_LOADED, ST_LATCH} state_t;
endpackage

// File: rtl/tlc_sequencer.sv
// tlc_sequencer: shifts grayscale data into a TLC driver, runs the GCLK PWM frame and
// latches each completed load during the blank gap between frames.
// Ports:
//   clk, rst            - system clock; asynchronous active-low reset
//   sclk_tick/gclk_tick - one-clk strobes from the SCLK/GCLK dividers
//   data_valid/data_bit - serial source handshake; data_ready marks a consume
//   sin, sclk_en        - serial data and its shift-clock enable (one clk of setup)
//   gclk_en, blank      - grayscale clock enable and driver blank
//   xlat, frame_done    - one-clk latch pulse and its completion strobe
module tlc_sequencer
  import tlc_pkg::*;
#(
  parameter int GS_BITS   = GS_BITS_DEF,
  parameter int SHIFT_LEN = SHIFT_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_tick,
  input  logic gclk_tick,
  input  logic data_valid,
  input  logic data_bit,
  output logic data_ready,
  output logic sin,
  output logic sclk_en,
  output logic gclk_en,
  output logic xlat,
  output logic blank,
  output logic frame_done
);
  localparam int BC_W = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(SHIFT_LEN - 1);

  state_t              r_state;
  state_t              w_next;
  logic [BC_W-1:0]     r_bit_cnt;
  logic [GS_BITS-1:0]  r_gs_cnt;
  logic                r_sin;
  logic                r_sclk_en;
  logic                r_gclk_en;
  logic                r_xlat;
  logic                r_frame_done;
  logic                r_blank;
  logic                r_latched;
  logic                w_consume;
  logic                w_last;
  logic                w_latch;
  logic                w_gs_run;
  logic                w_wrap;
  logic                w_unblank;

  assign data_ready = (r_state == ST_SHIFT) && sclk_tick;

  // r_latched limits the latch to once per blank gap, even if the next load
  // completes before blank falls; it is also what permits blank to fall.
  always_comb begin
    w_consume = data_valid && data_ready;
    w_last    = w_consume && (r_bit_cnt == LAST_BIT);
    w_latch   = (r_state == ST_LOADED) && r_blank && !r_latched;
    w_gs_run  = gclk_tick && !r_blank;
    w_wrap    = w_gs_run && (&r_gs_cnt);
    w_unblank = gclk_tick && r_blank && r_latched && !r_xlat;
    w_next    = r_state;
    w_next    = w_last ? ST_LOADED : w_latch ? ST_LATCH : (r_state == ST_LATCH) ? ST_SHIFT : r_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_SHIFT;
      r_bit_cnt    <= '0;
      r_gs_cnt     <= '0;
      r_sin        <= 1'b0;
      r_sclk_en    <= 1'b0;
      r_gclk_en    <= 1'b0;
      r_xlat       <= 1'b0;
      r_frame_done <= 1'b0;
      r_blank      <= 1'b1;
      r_latched    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_bit_cnt    <= w_last ? '0 : w_consume ? r_bit_cnt + 1'b1 : r_bit_cnt;
      r_gs_cnt     <= w_gs_run ? r_gs_cnt + 1'b1 : r_gs_cnt;
      r_sin        <= w_consume ? data_bit : r_sin;
      r_sclk_en    <= w_consume;
      r_gclk_en    <= w_gs_run;
      r_xlat       <= w_latch;
      r_frame_done <= w_latch;
      r_blank      <= w_wrap ? 1'b1 : w_unblank ? 1'b0 : r_blank;
      r_latched    <= w_latch ? 1'b1 : w_unblank ? 1'b0 : r_latched;
    end
  end

  assign sin        = r_sin;
  assign sclk_en    = r_sclk_en;
  assign gclk_en    = r_gclk_en;
  assign xlat       = r_xlat;
  assign blank      = r_blank;
  assign frame_done = r_frame_done;
endmodule

// File: tb/tb_tlc_sequencer.sv
// tb_tlc_sequencer: directed self-checking bench for tlc_sequencer with GS_BITS=3, SHIFT_LEN=4.
module tb_tlc_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk_tick = 1'b0;
  logic gclk_tick = 1'b0;
  logic data_valid = 1'b0;
  logic data_bit = 1'b0;
  logic data_ready, sin, sclk_en, gclk_en, xlat, blank, frame_done;
  logic rdy;
  int n_vec = 0;
  int n_err = 0;
  int n_gclk = 0, n_xlat = 0, n_fd = 0, n_blank = 0, n_clash = 0;
  int g0, x0, f0, b0;

  always #5 clk = ~clk;

  tlc_sequencer #(.GS_BITS(3), .SHIFT_LEN(4)) dut (
    .clk(clk), .rst(rst), .sclk_tick(sclk_tick), .gclk_tick(gclk_tick),
    .data_valid(data_valid), .data_bit(data_bit), .data_ready(data_ready),
    .sin(sin), .sclk_en(sclk_en), .gclk_en(gclk_en), .xlat(xlat),
    .blank(blank), .frame_done(frame_done)
  );

  always @(posedge clk) begin
    if (gclk_en) n_gclk++;
    if (xlat) n_xlat++;
    if (frame_done) n_fd++;
    if (blank) n_blank++;
    if (xlat && sclk_en) n_clash++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic st, input logic gt, input logic dv, input logic db);
    sclk_tick = st; gclk_tick = gt; data_valid = dv; data_bit = db;
    #1 rdy = data_ready;
    @(posedge clk) #1;
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("rst_blank", blank, 1); chk("rst_sin", sin, 0); chk("rst_sclk", sclk_en, 0);
    chk("rst_gclk", gclk_en, 0); chk("rst_xlat", xlat, 0); chk("rst_fd", frame_done, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    // first load: bits 1,0,1,1 then latch and unblank
    step(1,0,1,1); chk("s1_rdy", rdy, 1); chk("s1_sin0", sin, 1); chk("s1_sclk0", sclk_en, 1);
    step(0,0,1,0); chk("s1_sclk_pulse", sclk_en, 0);
    step(1,0,1,0); chk("s1_sin1", sin, 0); chk("s1_sclk1", sclk_en, 1);
    step(0,0,0,0);
    step(1,0,1,1); chk("s1_sin2", sin, 1);
    step(0,0,0,0);
    step(1,0,1,1); chk("s1_sin3", sin, 1); chk("s1_sclk3", sclk_en, 1); chk("s1_xlat_early", xlat, 0);
    step(1,0,1,0); chk("s1_loaded_rdy", rdy, 0); chk("s1_xlat", xlat, 1);
    chk("s1_fd", frame_done, 1); chk("s1_sclk_ign", sclk_en, 0);
    step(0,0,0,0); chk("s1_xlat_end", xlat, 0); chk("s1_fd_end", frame_done, 0); chk("s1_blank_hold", blank, 1);
    step(0,1,0,0); chk("s1_unblank", blank, 0); chk("s1_unblank_gclk", gclk_en, 0);
    // two steady frames: sclk every 2 clks, gclk every 4 clks
    g0 = n_gclk; x0 = n_xlat; f0 = n_fd; b0 = n_blank;
    for (int c = 0; c < 72; c++) step(c % 2 == 1, c % 4 == 3, c < 70, c[2]);
    chk("s2_gclk_cnt", n_gclk - g0, 16); chk("s2_xlat_cnt", n_xlat - x0, 2);
    chk("s2_fd_cnt", n_fd - f0, 2); chk("s2_blank_clks", n_blank - b0, 8); chk("s2_blank_end", blank, 0);
    // stall for 3 sclk ticks mid-load
    step(1,0,1,1); chk("s3_sin0", sin, 1);
    for (int i = 0; i < 3; i++) begin
      step(1,0,0,0); chk("s3_stall_sclk", sclk_en, 0); chk("s3_stall_sin", sin, 1);
    end
    step(1,0,1,0); chk("s3_sin1", sin, 0); chk("s3_sclk1", sclk_en, 1);
    step(1,0,1,1); chk("s3_sin2", sin, 1);
    step(1,0,1,0); chk("s3_sin3", sin, 0);
    step(1,0,1,1); chk("s3_loaded_rdy", rdy, 0); chk("s3_loaded_sclk", sclk_en, 0); chk("s3_loaded_sin", sin, 0);
    // finish frame, latch, then starve the next load
    for (int i = 0; i < 8; i++) step(0,1,0,0);
    chk("s4_final_gclk", gclk_en, 1); chk("s4_wrap_blank", blank, 1);
    step(0,0,0,0); chk("s4_xlat", xlat, 1);
    step(0,0,0,0);
    step(0,1,0,0); chk("s4_unblank", blank, 0);
    for (int i = 0; i < 8; i++) step(0,1,0,0);
    chk("s4_starve_blank", blank, 1);
    for (int i = 0; i < 2; i++) begin
      step(0,1,0,0); chk("s4_hold_gclk", gclk_en, 0); chk("s4_hold_blank", blank, 1);
    end
    step(1,1,1,1); step(1,1,1,0); step(1,1,1,1);
    chk("s4_part_blank", blank, 1); chk("s4_part_gclk", gclk_en, 0); chk("s4_part_xlat", xlat, 0);
    step(1,1,1,0); chk("s4_last_sclk", sclk_en, 1); chk("s4_last_xlat", xlat, 0);
    step(0,1,0,0); chk("s4_xlat2", xlat, 1); chk("s4_xlat2_blank", blank, 1); chk("s4_xlat2_sclk", sclk_en, 0);
    step(0,0,0,0); chk("s4_xlat2_end", xlat, 0);
    step(0,1,0,0); chk("s4_unblank2", blank, 0); chk("s4_unblank2_gclk", gclk_en, 0);
    // last bit consumed on the same edge blank rises
    for (int i = 0; i < 3; i++) step(1,0,1,1);
    for (int i = 0; i < 7; i++) step(0,1,0,0);
    chk("s5_pre_blank", blank, 0);
    step(1,1,1,1); chk("s5_sclk", sclk_en, 1); chk("s5_gclk", gclk_en, 1);
    chk("s5_blank", blank, 1); chk("s5_xlat_early", xlat, 0);
    step(0,0,0,0); chk("s5_xlat", xlat, 1); chk("s5_fd", frame_done, 1); chk("s5_xlat_sclk", sclk_en, 0);
    step(0,0,0,0); chk("s5_xlat_end", xlat, 0);
    step(0,1,0,0); chk("s5_unblank", blank, 0);
    chk("xlat_sclk_overlap", n_clash, 0);
    // asynchronous reset after 2 bits discards the partial load
    step(1,0,1,0);
    step(1,1,1,1); chk("s6_pre_sin", sin, 1); chk("s6_pre_gclk", gclk_en, 1);
    rst = 1'b0;
    #2;
    chk("s6_rst_sin", sin, 0); chk("s6_rst_sclk", sclk_en, 0); chk("s6_rst_gclk", gclk_en, 0);
    chk("s6_rst_blank", blank, 1); chk("s6_rst_xlat", xlat, 0);
    #2 rst = 1'b1;
    step(1,0,1,1); step(1,0,1,0); step(1,0,1,1);
    step(1,0,0,0); chk("s6_still_shift", rdy, 1); chk("s6_no_xlat", xlat, 0);
    step(1,0,1,0); chk("s6_last_sclk", sclk_en, 1); chk("s6_last_sin", sin, 0);
    step(0,0,0,0); chk("s6_xlat", xlat, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tlc_sequencer.md
TLC_SEQUENCER -- requirements
Module: tlc_sequencer

Interface
REQ-001 SHALL have parameter GS_BITS, default 12: grayscale counter width; one PWM frame is 2^GS_BITS GCLK pulses.
REQ-002 SHALL have parameter SHIFT_LEN, default 288: serial bits per driver load.
REQ-003 SHALL have ports:
  - clk  in  1  system clock; the only clock.
  - rst  in  1  reset, asynchronous, active-low.
  - sclk_tick  in  1  one-clk strobe per SCLK period, from the SCLK divider.
  - gclk_tick  in  1  one-clk strobe per GCLK period, from the GCLK divider.
  - data_valid  in  1  source has a bit.
  - data_bit  in  1  serial data bit.
  - data_ready  out  1  bit accepted this cycle.
  - sin  out  1  serial data to driver.
  - sclk_en  out  1  shift-clock enable pulse to driver.
  - gclk_en  out  1  grayscale-clock enable pulse to driver.
  - xlat  out  1  latch pulse.
  - blank  out  1  driver blank.
  - frame_done  out  1  one-clk pulse per completed latch.

Function
REQ-004 SHALL implement states SHIFT, LOADED, LATCH.
REQ-005 data_ready SHALL be combinational: state==SHIFT && sclk_tick; a bit is consumed only when data_valid && data_ready.
REQ-006 On consume: sin SHALL register data_bit; sclk_en SHALL pulse high exactly one clk later, giving one clk of sin setup.
REQ-007 sclk_tick with data_valid low in SHIFT SHALL stall: no consume, no sclk_en, bit_cnt held.
REQ-008 bit_cnt SHALL count consumed bits; on consuming bit SHIFT_LEN-1, bit_cnt SHALL clear and state SHALL go SHIFT->LOADED.
REQ-009 In LOADED, sclk_tick SHALL be ignored and data_ready SHALL be 0.
REQ-010 gs_cnt (GS_BITS wide) SHALL increment on gclk_tick while blank==0.
REQ-011 gclk_en SHALL equal gclk_tick && !blank, registered with one-clk latency.
REQ-012 On gclk_tick with blank==0 and gs_cnt==2^GS_BITS-1:
  - gs_cnt SHALL wrap to 0.
  - blank SHALL rise on the same edge.
  - that final tick still produces gclk_en.
REQ-013 Latch condition: the first clk cycle with blank==1 and state==LOADED.
REQ-014 On the latch condition: state SHALL go LOADED->LATCH, and xlat SHALL be 1 for exactly one clk, registered in the LATCH cycle.
REQ-015 From LATCH, state SHALL go to SHIFT next cycle; frame_done SHALL pulse coincident with xlat.
REQ-016 blank SHALL fall on the first gclk_tick after xlat has pulsed; that tick SHALL NOT increment gs_cnt or produce gclk_en.
REQ-017 If blank==1 and state!=LOADED (source underrun), blank SHALL hold, gs_cnt SHALL hold at 0, and the latch SHALL occur as soon as LOADED is reached.
REQ-018 If the state becomes LOADED on the same edge blank rises, the latch SHALL occur in the following cycle, with no extra blank period.
REQ-019 Simultaneous sclk_tick and gclk_tick SHALL each be processed independently in the same cycle.
REQ-020 Neither xlat nor sclk_en SHALL ever be high in the same cycle as the other.

Reset
REQ-021 When rst is low, all registers SHALL clear immediately:
  - state=SHIFT, bit_cnt=0, gs_cnt=0.
  - sin, sclk_en, gclk_en, xlat, frame_done = 0.
  - blank=1.
REQ-022 After reset release, blank SHALL stay 1 until the first latch completes, per REQ-016.
REQ-023 Reset mid-shift SHALL discard the partial load; the next load starts at bit 0.

Structure
REQ-024 The state enum typedef and default GS_BITS/SHIFT_LEN constants SHALL live in shared package tlc_pkg.
REQ-025 The block SHALL be a single module with no sub-modules; tick strobes come from the existing clock dividers.

Verification (GS_BITS=3, SHIFT_LEN=4)
REQ-026 Reset, then data_valid=1 with bits 1,0,1,1 -> four sclk_en pulses, each 1 clk after a consume; sin sequence 1,0,1,1; then LOADED; first xlat, then blank falls on the next gclk_tick.
REQ-027 Steady run with continuous data -> exactly 8 gclk_en per frame; blank high for one gclk period; one xlat and one frame_done per frame.
REQ-028 data_valid low for 3 sclk_ticks mid-load -> no sclk_en and data_ready=0-consume during the gap; bit order preserved.
REQ-029 Source starved at frame end -> blank holds and gclk_en=0 until the 4th bit; xlat occurs 2 clks after that consume.
REQ-030 Last bit consumed on the same edge blank rises -> xlat the next cycle; sclk_en and xlat are never high in the same cycle.
REQ-031 rst low mid-load after 2 bits -> outputs take reset values asynchronously; the next load requires 4 fresh bits.
